// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard receiver that turns make/break scancodes into level-held move flags.
// Optional build macro PS2_ARROWS_EN adds extended arrow keys, OR-combined with the letter keys.
module ps2_move_decoder #(
    parameter int KEY_SET        = 0,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       move_up,
    output logic       move_down,
    output logic       move_right,
    output logic       move_left,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_UP    = (KEY_SET == 1) ? 8'h43 : 8'h1D;
    localparam logic [7:0] CODE_DOWN  = (KEY_SET == 1) ? 8'h42 : 8'h1B;
    localparam logic [7:0] CODE_RIGHT = (KEY_SET == 1) ? 8'h4B : 8'h23;
    localparam logic [7:0] CODE_LEFT  = (KEY_SET == 1) ? 8'h3B : 8'h1C;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BREAK     = 2'd1;
    localparam logic [1:0] ST_EXT       = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    // Held-key vectors are ordered {up, down, right, left}.
    function automatic logic [3:0] map_letter(input logic [7:0] code);
        logic [3:0] hit;
        hit = 4'b0000;
        if (code == CODE_UP)    hit[3] = 1'b1;
        if (code == CODE_DOWN)  hit[2] = 1'b1;
        if (code == CODE_RIGHT) hit[1] = 1'b1;
        if (code == CODE_LEFT)  hit[0] = 1'b1;
        return hit;
    endfunction

`ifdef PS2_ARROWS_EN
    function automatic logic [3:0] map_arrow(input logic [7:0] code);
        logic [3:0] hit;
        hit = 4'b0000;
        if (code == 8'h75) hit[3] = 1'b1;
        if (code == 8'h72) hit[2] = 1'b1;
        if (code == 8'h74) hit[1] = 1'b1;
        if (code == 8'h6B) hit[0] = 1'b1;
        return hit;
    endfunction
`endif

    logic             ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic             ps2_data_p0, ps2_data_p1;
    logic             fall;
    logic [3:0]       bit_cnt;
    logic [10:0]      shreg;
    logic [10:0]      shreg_next;
    logic             frame_ok;
    logic [TO_W-1:0]  to_cnt;
    logic [1:0]       state, state_next;
    logic [3:0]       letter_held, letter_next;
    logic [3:0]       move_vec;

    // Stage p0/p1: two-flop synchronizers; p2 holds the previous synchronized clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    assign fall       = ps2_clk_p2 & ~ps2_clk_p1;
    assign shreg_next = {ps2_data_p1, shreg[10:1]};
    assign frame_ok   = ~shreg_next[0] & shreg_next[10] & (^shreg_next[9:1]);

    // Frame assembly: the 11th edge is judged here so key_valid/frame_err land one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= 4'd0;
            shreg     <= 11'd0;
            to_cnt    <= '0;
            key_valid <= 1'b0;
            key_code  <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                shreg  <= shreg_next;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        key_valid <= 1'b1;
                        key_code  <= shreg_next[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                // A stalled keyboard left a partial frame; drop it and resync on the next start bit.
                bit_cnt   <= 4'd0;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

`ifdef PS2_ARROWS_EN
    logic [3:0] arrow_held, arrow_next;
`endif

    always_comb begin
        state_next  = state;
        letter_next = letter_held;
`ifdef PS2_ARROWS_EN
        arrow_next  = arrow_held;
`endif
        if (key_valid) begin
            case (state)
                ST_IDLE: begin
                    if (key_code == 8'hF0)      state_next = ST_BREAK;
                    else if (key_code == 8'hE0) state_next = ST_EXT;
                    else                        letter_next = letter_held | map_letter(key_code);
                end
                ST_BREAK: begin
                    letter_next = letter_held & ~map_letter(key_code);
                    state_next  = ST_IDLE;
                end
                ST_EXT: begin
                    if (key_code == 8'hF0) begin
                        state_next = ST_EXT_BREAK;
                    end else begin
`ifdef PS2_ARROWS_EN
                        arrow_next = arrow_held | map_arrow(key_code);
`endif
                        state_next = ST_IDLE;
                    end
                end
                default: begin
`ifdef PS2_ARROWS_EN
                    arrow_next = arrow_held & ~map_arrow(key_code);
`endif
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Decode stage: flags follow key_valid by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            letter_held <= 4'b0000;
`ifdef PS2_ARROWS_EN
            arrow_held  <= 4'b0000;
`endif
        end else begin
            state       <= state_next;
            letter_held <= letter_next;
`ifdef PS2_ARROWS_EN
            arrow_held  <= arrow_next;
`endif
        end
    end

`ifdef PS2_ARROWS_EN
    assign move_vec = letter_held | arrow_held;
`else
    assign move_vec = letter_held;
`endif

    assign move_up    = move_vec[3];
    assign move_down  = move_vec[2];
    assign move_right = move_vec[1];
    assign move_left  = move_vec[0];

endmodule
